simplez_core: RTL and testbench

//  Complete, parametrised SIMPLEZ processor core: program counter (CP), instruction

---
 rtl/simplez_core.sv | 129 ++++++++++++
 tb/tb_simplez_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplez_core.sv
// SIMPLEZ processor core: CP/RI/AC/Z registers plus a fetch/decode/operand/execute
// sequencer for a 1-cycle-latency synchronous memory, with HALT/resume and debug taps.
module simplez_core #(
  parameter int unsigned DATAW    = 12,
  parameter int unsigned ADDRW    = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cont,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             halted,
  output logic [ADDRW-1:0] pc,
  output logic [DATAW-1:0] acc,
  output logic [DATAW-1:0] ri
);
  localparam int unsigned OPW = 3;

  typedef enum logic [2:0] {
    OP_ST, OP_LD, OP_ADD, OP_BR, OP_BZ, OP_CLR, OP_DEC, OP_HALT
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPER, S_EXEC, S_HALTED
  } state_e;

  state_e           state, state_nxt;
  logic [ADDRW-1:0] pc_nxt;
  logic [DATAW-1:0] acc_nxt, ri_nxt;
  logic             z, z_nxt;
  logic [ADDRW-1:0] addr_c;
  logic             rd_c, wr_c;

  op_e              dec_op, ri_op;
  logic [ADDRW-1:0] dec_cd, ri_cd, pc_inc;
  logic [DATAW-1:0] acc_sum, acc_dec;

  // Decode straight from the read bus in DECODE; later states use the latched RI.
  assign dec_op  = op_e'(mem_rdata[DATAW-1 -: OPW]);
  assign dec_cd  = mem_rdata[ADDRW-1:0];
  assign ri_op   = op_e'(ri[DATAW-1 -: OPW]);
  assign ri_cd   = ri[ADDRW-1:0];
  assign pc_inc  = pc + ADDRW'(1);
  assign acc_sum = acc + mem_rdata;
  assign acc_dec = acc - DATAW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_FETCH;
      pc    <= ADDRW'(RESET_PC);
      acc   <= '0;
      z     <= 1'b1;
      ri    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc   <= acc_nxt;
      z     <= z_nxt;
      ri    <= ri_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    z_nxt     = z;
    ri_nxt    = ri;
    addr_c    = pc;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    case (state)
      S_FETCH: begin
        rd_c      = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ri_nxt    = mem_rdata;
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
        case (dec_op)
          OP_ST, OP_LD, OP_ADD: state_nxt = S_OPER;
          OP_BR:   pc_nxt = dec_cd;
          OP_BZ:   if (z) pc_nxt = dec_cd;
          OP_CLR: begin
            acc_nxt = '0;
            z_nxt   = 1'b1;
          end
          OP_DEC: begin
            acc_nxt = acc_dec;
            z_nxt   = (acc_dec == '0);
          end
          OP_HALT: state_nxt = S_HALTED;
        endcase
      end
      S_OPER: begin
        addr_c = ri_cd;
        if (ri_op == OP_ST) begin
          wr_c      = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          rd_c      = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_nxt   = (ri_op == OP_LD) ? mem_rdata : acc_sum;
        z_nxt     = (acc_nxt == '0);
        state_nxt = S_FETCH;
      end
      S_HALTED: begin
        if (cont) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Strobes and halted are gated by reset so an interrupted ST never lands.
  assign mem_addr  = addr_c;
  assign mem_rd    = rd_c & rstn;
  assign mem_wr    = wr_c & rstn;
  assign mem_wdata = acc;
  assign halted    = rstn & (state == S_HALTED);

endmodule

// File: tb/tb_simplez_core.sv
// Scoreboard bench for simplez_core: an instruction-level model predicts the memory
// bus trace and halt state; a monitor compares them against the core as it runs.
module tb_simplez_core;
  localparam int unsigned DATAW = 12;
  localparam int unsigned ADDRW = 9;
  localparam int K_RD = 0, K_WR = 1, K_HALT = 2;

  typedef struct {
    int               kind;
    logic [ADDRW-1:0] addr;  // access address, or pc for a halt
    logic [DATAW-1:0] data;  // write data, or acc for a halt
    int               cyc;   // cycles from start to halted (halt only)
  } ev_t;

  logic             clk, rstn, cont;
  logic [ADDRW-1:0] mem_addr, pc;
  logic             mem_rd, mem_wr, halted;
  logic [DATAW-1:0] mem_wdata, mem_rdata, acc, ri;

  logic             ld_en;
  logic [ADDRW-1:0] ld_addr;
  logic [DATAW-1:0] ld_data;
  logic [DATAW-1:0] tb_mem [512];

  logic [DATAW-1:0] m_mem [512];
  logic [ADDRW-1:0] m_pc;
  logic [DATAW-1:0] m_ac;
  logic             m_z;

  ev_t exp_q[$];
  int  errors = 0, checks = 0;
  int  cyc_count = 0, start_cyc = 0;
  int  halts_seen = 0, halts_exp = 0;

  simplez_core #(.DATAW(DATAW), .ADDRW(ADDRW), .RESET_PC(0)) dut (
    .clk(clk), .rstn(rstn), .cont(cont),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .halted(halted), .pc(pc), .acc(acc), .ri(ri)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Synchronous memory with a bench-side load port used only while the core is in reset.
  always @(posedge clk) begin
    if (ld_en) tb_mem[ld_addr] <= ld_data;
    else if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= tb_mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] ins(input int op, input int cd);
    return {3'(op), ADDRW'(cd)};
  endfunction

  task automatic push(input int kind, input logic [ADDRW-1:0] a,
                      input logic [DATAW-1:0] d, input int c);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Instruction-set model: runs to the next HALT, queuing every bus access and the halt.
  task automatic model_run(input int base_cyc);
    int               cyc;
    logic [DATAW-1:0] w;
    logic [ADDRW-1:0] cd;
    cyc = base_cyc;
    for (int s = 0; s < 1000; s++) begin
      w  = m_mem[m_pc];
      cd = w[ADDRW-1:0];
      push(K_RD, m_pc, '0, 0);
      m_pc = m_pc + 9'd1;
      case (int'(w[DATAW-1 -: 3]))
        0: begin push(K_WR, cd, m_ac, 0); m_mem[cd] = m_ac; cyc += 3; end
        1: begin push(K_RD, cd, '0, 0); m_ac = m_mem[cd]; m_z = (m_ac == 0); cyc += 4; end
        2: begin push(K_RD, cd, '0, 0); m_ac = m_ac + m_mem[cd]; m_z = (m_ac == 0); cyc += 4; end
        3: begin m_pc = cd; cyc += 2; end
        4: begin if (m_z) m_pc = cd; cyc += 2; end
        5: begin m_ac = '0; m_z = 1'b1; cyc += 2; end
        6: begin m_ac = m_ac - 12'd1; m_z = (m_ac == 0); cyc += 2; end
        default: begin cyc += 2; push(K_HALT, m_pc, m_ac, cyc); return; end
      endcase
    end
    checks++; errors++;
    $display("FAIL model_run: program did not halt");
  endtask

  // Monitor: every strobe and every halt entry consumes one expected event.
  initial begin
    ev_t  e;
    logic prev_h;
    prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access: addr=%0d wr=%0d, none expected", mem_addr, mem_wr);
        end else begin
          e = exp_q.pop_front();
          chk("access_kind", 32'(mem_wr), 32'(e.kind));
          chk("access_addr", 32'(mem_addr), 32'(e.addr));
          if (e.kind == K_WR) chk("write_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (halted && !prev_h) begin
        halts_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_halt: pc=%0d, none expected", pc);
        end else begin
          e = exp_q.pop_front();
          chk("halt_kind", 32'(K_HALT), 32'(e.kind));
          if (e.kind == K_HALT) begin
            chk("halt_pc", 32'(pc), 32'(e.addr));
            chk("halt_acc", 32'(acc), 32'(e.data));
            chk("halt_cycles", 32'(cyc_count - start_cyc), 32'(e.cyc));
          end
        end
      end
      prev_h = halted;
    end
  end

  task automatic poke(input int a, input logic [DATAW-1:0] d);
    m_mem[a] = d;
    ld_en = 1'b1; ld_addr = ADDRW'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_halts();
    for (int a = 0; a < 32; a++) poke(a, ins(7, 0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_rd", 32'(mem_rd), 32'd0);
    chk("reset_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_acc", 32'(acc), 32'd0);
  endtask

  task automatic wait_halt();
    int n = 0;
    while (halts_seen < halts_exp && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("halt_reached", 32'(halts_seen >= halts_exp), 32'd1);
    if (halts_seen < halts_exp) halts_exp = halts_seen;
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_prog(input bit first_chk);
    m_pc = '0; m_ac = '0; m_z = 1'b1;
    model_run(0);
    halts_exp++;
    rstn = 1'b1;
    start_cyc = cyc_count;
    if (first_chk) begin
      #1;
      chk("first_rd", 32'(mem_rd), 32'd1);
      chk("first_addr", 32'(mem_addr), 32'd0);
      chk("first_acc", 32'(acc), 32'd0);
      chk("first_halted", 32'(halted), 32'd0);
    end
    wait_halt();
  endtask

  task automatic resume();
    model_run(1);
    halts_exp++;
    cont = 1'b1;
    start_cyc = cyc_count;
    @(posedge clk); #1;
    cont = 1'b0;
    wait_halt();
  endtask

  initial begin
    int op, cd;
    rstn = 1'b0; cont = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int a = 0; a < 512; a++) m_mem[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_ri", 32'(ri), 32'd0);

    // LD/ADD/ST/HALT: 13 cycles, M[102]=12
    load_halts();
    poke(0, ins(1, 100)); poke(1, ins(2, 101)); poke(2, ins(0, 102)); poke(3, ins(7, 0));
    poke(100, 12'd5); poke(101, 12'd7); poke(102, 12'd0);
    run_prog(1'b1);
    chk("t2_mem102", 32'(tb_mem[102]), 32'd12);
    chk("t2_pc", 32'(pc), 32'd4);

    // CLR; DEC; BZ 0 (not taken); HALT; then resume into HALT at 4
    do_reset();
    load_halts();
    poke(0, ins(5, 0)); poke(1, ins(6, 0)); poke(2, ins(4, 0)); poke(3, ins(7, 0));
    run_prog(1'b0);
    chk("t3_acc", 32'(acc), 32'hFFF);
    chk("t3_pc", 32'(pc), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_stays_halted", 32'(halted), 32'd1);
    resume();
    chk("t3_resume_pc", 32'(pc), 32'd5);

    // Branch chain 510 -> 511 -> 0 via BR 511 / BR 0
    do_reset();
    load_halts();
    poke(0, ins(4, 4)); poke(4, ins(6, 0)); poke(5, ins(3, 510));
    poke(510, ins(3, 511)); poke(511, ins(3, 0));
    run_prog(1'b0);
    chk("t4_pc", 32'(pc), 32'd2);

    // Non-branch at 511 wraps CP to 0
    do_reset();
    load_halts();
    poke(0, ins(4, 511)); poke(511, ins(6, 0));
    run_prog(1'b0);
    chk("t4_wrap_pc", 32'(pc), 32'd2);

    // ADD overflow to zero sets Z, so BZ is taken
    do_reset();
    load_halts();
    poke(0, ins(6, 0)); poke(1, ins(2, 200)); poke(2, ins(4, 5)); poke(200, 12'd1);
    run_prog(1'b0);
    chk("t5_acc", 32'(acc), 32'd0);
    chk("t5_pc", 32'(pc), 32'd6);

    // Reset in the OPER cycle of an ST must suppress the write
    do_reset();
    load_halts();
    poke(0, ins(6, 0)); poke(1, ins(0, 300)); poke(300, 12'h123);
    push(K_RD, 9'd0, '0, 0);
    push(K_RD, 9'd1, '0, 0);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_wr_pending", 32'(mem_wr), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_wr_blocked", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    chk("t6_pc_restart", 32'(pc), 32'd0);
    chk("t6_mem_kept", 32'(tb_mem[300]), 32'h123);
    chk("t6_events_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_prog(1'b0);
    chk("t6_mem_written", 32'(tb_mem[300]), 32'hFFF);

    // Random forward-branching programs, each halted and resumed once
    for (int p = 0; p < 12; p++) begin
      do_reset();
      load_halts();
      for (int i = 0; i < 15; i++) begin
        op = int'($urandom_range(7, 0));
        if (op == 7 && $urandom_range(3, 0) != 0) op = 2;
        if (op <= 2) cd = 400 + int'($urandom_range(15, 0));
        else if (op == 3 || op == 4) cd = int'($urandom_range(15, i + 1));
        else cd = int'($urandom_range(511, 0));
        poke(i, ins(op, cd));
      end
      for (int a = 400; a < 416; a++) poke(a, DATAW'($urandom));
      run_prog(1'b0);
      resume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
